ldpc_dvb_dec_srl_fifo_reader: RTL and testbench



---
 rtl/ldpc_dvb_dec_fifo_pkg.sv | 13 +
 rtl/ldpc_dvb_dec_skid_buf2.sv | 56 +++++
 rtl/ldpc_dvb_dec_srl_fifo_reader.sv | 95 +++++++++
 tb/tb_ldpc_dvb_dec_srl_fifo_reader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_dvb_dec_fifo_pkg.sv
// Shared types for the SRL FIFO read-side controller and its 2-entry skid buffer.
package ldpc_dvb_dec_fifo_pkg;

    localparam int cBUF_DEPTH = 2;

    typedef logic [1:0] buf_cnt_t;

    typedef struct packed {
        logic sop;
        logic eop;
    } frame_tag_t;

endpackage

// File: rtl/ldpc_dvb_dec_skid_buf2.sv
// Two-entry register FIFO used to absorb the one-cycle read latency of the SRL FIFO.
module ldpc_dvb_dec_skid_buf2
    import ldpc_dvb_dec_fifo_pkg::*;
#(
    parameter int pDAT_W = 8
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              iclkena,
    input  logic              iclear,
    input  logic              push,
    input  logic [pDAT_W-1:0] wdat,
    input  logic              pop,
    output logic [pDAT_W-1:0] rdat,
    output buf_cnt_t          cnt
);

    logic [pDAT_W-1:0] mem [cBUF_DEPTH];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              do_pop;

    // An empty buffer never advances its head, whatever the caller asks.
    assign do_pop = pop && (cnt != '0);
    assign rdat   = mem[rd_ptr];

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= '0;
        end else if (iclkena) begin
            if (iclear) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
                cnt    <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= wdat;
                    wr_ptr      <= ~wr_ptr;
                end
                if (do_pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                case ({push, do_pop})
                    2'b10:   cnt <= cnt + buf_cnt_t'(1);
                    2'b01:   cnt <= cnt - buf_cnt_t'(1);
                    default: cnt <= cnt;
                endcase
            end
        end
    end

endmodule

// File: rtl/ldpc_dvb_dec_srl_fifo_reader.sv
// Drains a 1-cycle-latency SRL FIFO into a valid/ready stream with sop/eop framing.
module ldpc_dvb_dec_srl_fifo_reader
    import ldpc_dvb_dec_fifo_pkg::*;
#(
    parameter int pDAT_W = 8,
    parameter int pLEN_W = 16
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              iclkena,
    input  logic              iclear,
    input  logic [pLEN_W-1:0] iframe_len,
    input  logic              ifempty,
    output logic              ofread,
    input  logic              ifrval,
    input  logic [pDAT_W-1:0] ifrdat,
    output logic              oval,
    output logic [pDAT_W-1:0] odat,
    output logic              osop,
    output logic              oeop,
    input  logic              iready,
    output logic              obusy
);

    localparam logic [pLEN_W-1:0] cONE = 1;

    buf_cnt_t          buf_cnt;
    logic              inflight;
    logic [pLEN_W-1:0] wcnt;
    logic [pLEN_W-1:0] len_r;
    logic [pLEN_W-1:0] len_cur;
    logic [2:0]        occ;
    logic [2:0]        occ_after;
    logic              pop;
    frame_tag_t        tag;
    logic [pDAT_W-1:0] head_dat;

    assign pop       = oval & iready & iclkena;
    assign occ       = {1'b0, buf_cnt} + {2'b00, inflight};
    assign occ_after = occ - {2'b00, pop};

    // Credit rule: only read when the word will still have a slot when it lands.
    assign ofread = iclkena & ~iclear & ~ifempty & (occ_after < 3'd2);

    // The first word of a frame has to see the new length before len_r captures it.
    assign len_cur = (wcnt == '0) ? iframe_len : len_r;
    assign tag.sop = (wcnt == '0);
    assign tag.eop = (wcnt == (len_cur - cONE));

    assign oval  = (buf_cnt != '0);
    assign odat  = head_dat;
    assign osop  = oval & tag.sop;
    assign oeop  = oval & tag.eop;
    assign obusy = (occ != 3'd0);

    ldpc_dvb_dec_skid_buf2 #(
        .pDAT_W (pDAT_W)
    ) u_buf (
        .iclk    (iclk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .iclear  (iclear),
        .push    (ifrval),
        .wdat    (ifrdat),
        .pop     (pop),
        .rdat    (head_dat),
        .cnt     (buf_cnt)
    );

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            inflight <= 1'b0;
            wcnt     <= '0;
            len_r    <= '0;
        end else if (iclkena) begin
            if (iclear) begin
                inflight <= 1'b0;
                wcnt     <= '0;
            end else begin
                inflight <= ofread;
                if (wcnt == '0) begin
                    len_r <= iframe_len;
                end
                if (pop) begin
                    wcnt <= tag.eop ? '0 : (wcnt + cONE);
                end
            end
        end
    end

    overflow_chk : assert property (@(posedge iclk) disable iff (ireset)
        !(iclkena && !iclear && ifrval && (buf_cnt == buf_cnt_t'(cBUF_DEPTH)) && !pop))
        else $error("skid buffer push while full");

endmodule

// File: tb/tb_ldpc_dvb_dec_srl_fifo_reader.sv
// Directed bench for the SRL FIFO reader: behavioural 1-cycle-latency FIFO plus output capture.
module tb_ldpc_dvb_dec_srl_fifo_reader;

    localparam int pDAT_W = 8;
    localparam int pLEN_W = 16;

    typedef struct {
        logic [7:0] dat;
        logic       sop;
        logic       eop;
        int         stamp;
    } rx_t;

    logic              iclk = 1'b0;
    logic              ireset = 1'b1;
    logic              iclkena = 1'b0;
    logic              iclear = 1'b0;
    logic [pLEN_W-1:0] iframe_len = 16'd4;
    logic              ifempty;
    logic              ofread;
    logic              ifrval = 1'b0;
    logic [7:0]        ifrdat = 8'h00;
    logic              oval;
    logic [7:0]        odat;
    logic              osop;
    logic              oeop;
    logic              iready = 1'b0;
    logic              obusy;

    logic       fwr = 1'b0;
    logic [7:0] fwdat = 8'h00;
    logic [7:0] fq [$];
    int         fcount = 0;

    rx_t  rxq [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ena_cyc = 0;
    int   rd_cnt = 0;
    int   val_cnt = 0;
    int   first_rd = -1;
    int   first_val = -1;
    logic prev_hold = 1'b0;
    logic [7:0] prev_dat = 8'h00;

    always #5 iclk = ~iclk;

    ldpc_dvb_dec_srl_fifo_reader #(
        .pDAT_W (pDAT_W),
        .pLEN_W (pLEN_W)
    ) dut (
        .iclk       (iclk),
        .ireset     (ireset),
        .iclkena    (iclkena),
        .iclear     (iclear),
        .iframe_len (iframe_len),
        .ifempty    (ifempty),
        .ofread     (ofread),
        .ifrval     (ifrval),
        .ifrdat     (ifrdat),
        .oval       (oval),
        .odat       (odat),
        .osop       (osop),
        .oeop       (oeop),
        .iready     (iready),
        .obusy      (obusy)
    );

    assign ifempty = (fcount == 0);

    // Behavioural SRL FIFO: ungated write port, read port gated by iclkena like the real one.
    always @(posedge iclk) begin
        if (fwr) fq.push_back(fwdat);
        if (ireset) begin
            ifrval <= 1'b0;
        end else if (iclkena) begin
            if (iclear) begin
                fq.delete();
                ifrval <= 1'b0;
            end else begin
                ifrval <= ofread;
                if (ofread && fq.size() != 0) begin
                    ifrdat <= fq[0];
                    void'(fq.pop_front());
                end
            end
        end
        fcount <= fq.size();
        cyc <= cyc + 1;
        if (iclkena) ena_cyc <= ena_cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output capture at the falling edge, where inputs and DUT state are settled.
    always @(negedge iclk) begin
        if (!ireset) begin
            if (prev_hold) checkOutput("hold", {23'd0, oval, odat}, {23'd0, 1'b1, prev_dat});
            prev_hold = oval & ~iready & ~iclear;
            prev_dat  = odat;
            if (iclkena && ofread) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (iclkena && oval) begin
                val_cnt++;
                if (first_val < 0) first_val = cyc;
            end
            if (iclkena && oval && iready) rxq.push_back('{odat, osop, oeop, ena_cyc});
        end
    end

    task automatic applyStimulus(input logic ena, input logic rdy, input logic clr);
        iclkena = ena;
        iready  = rdy;
        iclear  = clr;
        @(posedge iclk);
        #1;
    endtask

    task automatic fifoLoad(input logic [7:0] first, input int n);
        iclkena = 1'b0;
        iclear  = 1'b0;
        for (int i = 0; i < n; i++) begin
            fwr   = 1'b1;
            fwdat = first + 8'(i);
            @(posedge iclk);
            #1;
        end
        fwr = 1'b0;
    endtask

    task automatic startTest();
        rxq.delete();
        rd_cnt    = 0;
        val_cnt   = 0;
        first_rd  = -1;
        first_val = -1;
    endtask

    task automatic checkFrame(input logic [7:0] first, input int n, input int len, input bit cont);
        checkOutput("count", rxq.size(), n);
        for (int i = 0; i < rxq.size() && i < n; i++) begin
            checkOutput($sformatf("dat%0d", i), {24'd0, rxq[i].dat}, {24'd0, first + 8'(i)});
            checkOutput($sformatf("sop%0d", i), {31'd0, rxq[i].sop}, {31'd0, (i % len) == 0});
            checkOutput($sformatf("eop%0d", i), {31'd0, rxq[i].eop}, {31'd0, (i % len) == len - 1});
        end
        if (cont && rxq.size() == n && n > 0)
            checkOutput("contiguous", rxq[n-1].stamp - rxq[0].stamp, n - 1);
    endtask

    initial begin
        logic [7:0] snap_dat;
        logic [3:0] pat;

        repeat (3) @(posedge iclk);
        #1;
        ireset = 1'b0;
        @(posedge iclk);
        #1;
        checkOutput("rst_oval", {31'd0, oval}, 0);
        checkOutput("rst_osop", {31'd0, osop}, 0);
        checkOutput("rst_oeop", {31'd0, oeop}, 0);
        checkOutput("rst_obusy", {31'd0, obusy}, 0);
        checkOutput("rst_odat", {24'd0, odat}, 0);
        checkOutput("rst_ofread", {31'd0, ofread}, 0);

        $display("[TB] test 1: full-rate frames of 4");
        iframe_len = 16'd4;
        startTest();
        fifoLoad(8'h11, 8);
        repeat (14) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t1_latency", first_val - first_rd, 2);
        checkFrame(8'h11, 8, 4, 1'b1);
        checkOutput("t1_idle", {31'd0, obusy}, 0);

        $display("[TB] test 2: ready toggling 1,0,0,1");
        startTest();
        fifoLoad(8'h11, 8);
        pat = 4'b1001;
        for (int k = 0; k < 48; k++) applyStimulus(1'b1, pat[3 - (k % 4)], 1'b0);
        checkFrame(8'h11, 8, 4, 1'b0);
        checkOutput("t2_idle", {31'd0, obusy}, 0);

        $display("[TB] test 3: single-word frames");
        iframe_len = 16'd1;
        startTest();
        fifoLoad(8'hA0, 3);
        repeat (10) applyStimulus(1'b1, 1'b1, 1'b0);
        checkFrame(8'hA0, 3, 1, 1'b1);

        $display("[TB] test 4: underrun with one word");
        startTest();
        fifoLoad(8'h5A, 1);
        repeat (8) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t4_reads", rd_cnt, 1);
        checkOutput("t4_valids", val_cnt, 1);
        checkFrame(8'h5A, 1, 1, 1'b1);
        checkOutput("t4_obusy", {31'd0, obusy}, 0);
        checkOutput("t4_ofread", {31'd0, ofread}, 0);

        $display("[TB] test 5: clear with a read in flight");
        iframe_len = 16'd4;
        startTest();
        fifoLoad(8'h31, 4);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t5_pre_oval", {31'd0, oval}, 1);
        checkOutput("t5_pre_odat", {24'd0, odat}, 32'h31);
        checkOutput("t5_pre_obusy", {31'd0, obusy}, 1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("t5_oval", {31'd0, oval}, 0);
        checkOutput("t5_obusy", {31'd0, obusy}, 0);
        checkOutput("t5_ofread", {31'd0, ofread}, 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t5_rx_empty", rxq.size(), 0);
        checkOutput("t5_still_idle", {31'd0, obusy}, 0);
        fifoLoad(8'h41, 4);
        repeat (12) applyStimulus(1'b1, 1'b1, 1'b0);
        checkFrame(8'h41, 4, 4, 1'b1);

        $display("[TB] test 6: clock-enable pause mid-stream");
        startTest();
        fifoLoad(8'h61, 8);
        repeat (4) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t6_head", {24'd0, odat}, 32'h63);
        snap_dat = odat;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput("t6_frz_oval", {31'd0, oval}, 1);
            checkOutput("t6_frz_odat", {24'd0, odat}, {24'd0, snap_dat});
            checkOutput("t6_frz_obusy", {31'd0, obusy}, 1);
            checkOutput("t6_frz_ofread", {31'd0, ofread}, 0);
        end
        repeat (14) applyStimulus(1'b1, 1'b1, 1'b0);
        checkFrame(8'h61, 8, 4, 1'b1);
        checkOutput("t6_idle", {31'd0, obusy}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
